// File: rtl/gb_vga_scaler_if.sv
// Framebuffer read port and VGA output bundle of the GB scaler.
// master = scaler side, slave = framebuffer / display side.
interface gb_vga_scaler_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 2
);
  logic [ADDR_W-1:0]  fb_addr;
  logic [1:0]         fb_data;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               frame_start;

  modport master (
    output fb_addr,
    input  fb_data,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output frame_start
  );

  modport slave (
    input  fb_addr,
    output fb_data,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  frame_start
  );
endinterface

// File: rtl/gb_vga_scaler.sv
// VGA output stage: timing, integer-scaled framebuffer fetch,
// palette lookup and border fill in the 25 MHz pixel domain.
module gb_vga_scaler #(
  parameter int H_PIXELS = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int H_POL    = 0,
  parameter int V_PIXELS = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter int V_POL    = 1,
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 3,
  parameter int X_OFF    = 80,
  parameter int Y_OFF    = 24,
  parameter int ADDR_W   = 15,
  parameter int COLOR_W  = 2
) (
  input  logic                 CLK_25MHz,
  input  logic                 reset,
  gb_vga_scaler_if.master      vga,
  input  logic                 pal_we,
  input  logic [1:0]           pal_idx,
  input  logic [3*COLOR_W-1:0] pal_rgb,
  input  logic [3*COLOR_W-1:0] border_rgb
);

  localparam int H_FRAME = H_PIXELS + H_FP + H_PULSE + H_BP;
  localparam int V_FRAME = V_PIXELS + V_FP + V_PULSE + V_BP;
  localparam int HW = $clog2(H_FRAME);
  localparam int VW = $clog2(V_FRAME);
  localparam int XW = $clog2(SRC_W + 1);
  localparam int SW = $clog2(SCALE + 1);
  localparam int CW = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_FRAME - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_PIXELS);
  localparam logic [HW-1:0] HS_ON  = HW'(H_PIXELS + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_PIXELS + H_FP + H_PULSE - 1);
  localparam logic [HW-1:0] WX0 = HW'(X_OFF);
  localparam logic [HW-1:0] WX1 = HW'(X_OFF + SRC_W * SCALE - 1);

  localparam logic [VW-1:0] V_LAST = VW'(V_FRAME - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_PIXELS);
  localparam logic [VW-1:0] VS_ON  = VW'(V_PIXELS + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_PIXELS + V_FP + V_PULSE - 1);
  localparam logic [VW-1:0] WY0 = VW'(Y_OFF);
  localparam logic [VW-1:0] WY1 = VW'(Y_OFF + SRC_H * SCALE - 1);

  localparam logic [SW-1:0]     S_LAST  = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(SRC_W);
  localparam logic HS_ACT = 1'(H_POL);
  localparam logic VS_ACT = 1'(V_POL);

  localparam int FULL = (1 << COLOR_W) - 1;
  localparam logic [COLOR_W-1:0] L0 = COLOR_W'(FULL);
  localparam logic [COLOR_W-1:0] L1 = COLOR_W'(FULL * 2 / 3);
  localparam logic [COLOR_W-1:0] L2 = COLOR_W'(FULL / 3);
  localparam logic [COLOR_W-1:0] L3 = '0;

  if (SCALE < 1) begin : g_bad_scale
    $error("SCALE must be at least 1");
  end
  if (X_OFF + SRC_W * SCALE > H_PIXELS) begin : g_bad_x
    $error("scaled image exceeds visible width");
  end
  if (Y_OFF + SRC_H * SCALE > V_PIXELS) begin : g_bad_y
    $error("scaled image exceeds visible height");
  end
  if (SRC_W * SRC_H > (1 << ADDR_W)) begin : g_bad_addr
    $error("source image does not fit ADDR_W");
  end

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [SW-1:0]     x_sub;
  logic [SW-1:0]     y_sub;
  logic [XW-1:0]     src_x;
  logic [ADDR_W-1:0] line_base;

  logic in_x;
  logic in_y;
  logic vis;
  logic hs_on;
  logic vs_on;

  assign in_x  = (h >= WX0) && (h <= WX1);
  assign in_y  = (v >= WY0) && (v <= WY1);
  assign vis   = (h < H_VIS) && (v < V_VIS);
  assign hs_on = (h >= HS_ON) && (h <= HS_END);
  assign vs_on = (v >= VS_ON) && (v <= VS_END);

  // S0: raster counters and incremental source coordinates
  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      x_sub     <= '0;
      y_sub     <= '0;
      src_x     <= '0;
      line_base <= '0;
    end else begin
      h <= (h == H_LAST) ? '0 : h + HW'(1);
      if (in_x && (h != WX1)) begin
        if (x_sub == S_LAST) begin
          x_sub <= '0;
          src_x <= src_x + XW'(1);
        end else begin
          x_sub <= x_sub + SW'(1);
        end
      end else begin
        x_sub <= '0;
        src_x <= '0;
      end
      if (h == H_LAST) begin
        v <= (v == V_LAST) ? '0 : v + VW'(1);
        if (in_y && (v != WY1)) begin
          if (y_sub == S_LAST) begin
            y_sub     <= '0;
            line_base <= line_base + LB_STEP;
          end else begin
            y_sub <= y_sub + SW'(1);
          end
        end else begin
          y_sub     <= '0;
          line_base <= '0;
        end
      end
    end
  end

  logic s1_win;
  logic s1_vis;
  logic s1_hs;
  logic s1_vs;
  logic s1_first;

  // S1: address out, flags follow it
  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      vga.fb_addr <= '0;
      s1_win      <= 1'b0;
      s1_vis      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_first    <= 1'b0;
    end else begin
      vga.fb_addr <= line_base + ADDR_W'(src_x);
      s1_win      <= in_x && in_y;
      s1_vis      <= vis;
      s1_hs       <= hs_on;
      s1_vs       <= vs_on;
      s1_first    <= (h == '0) && (v == '0);
    end
  end

  logic [CW-1:0] pal [4];
  logic [CW-1:0] pix;
  logic [CW-1:0] rgb_nxt;

  assign pix = pal[vga.fb_data];

  always_comb begin
    rgb_nxt = '0;
    unique case (1'b1)
      !s1_vis:           rgb_nxt = '0;
      s1_vis && s1_win:  rgb_nxt = pix;
      s1_vis && !s1_win: rgb_nxt = border_rgb;
    endcase
  end

  // S2: lookup sees the palette before any same-edge write
  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      vga.vga_r       <= '0;
      vga.vga_g       <= '0;
      vga.vga_b       <= '0;
      vga.vga_hs      <= ~HS_ACT;
      vga.vga_vs      <= ~VS_ACT;
      vga.frame_start <= 1'b0;
    end else begin
      {vga.vga_r, vga.vga_g, vga.vga_b} <= rgb_nxt;
      vga.vga_hs      <= s1_hs ? HS_ACT : ~HS_ACT;
      vga.vga_vs      <= s1_vs ? VS_ACT : ~VS_ACT;
      vga.frame_start <= s1_first;
    end
  end

  always_ff @(posedge CLK_25MHz) begin
    if (reset) begin
      pal[0] <= {L0, L0, L0};
      pal[1] <= {L1, L1, L1};
      pal[2] <= {L2, L2, L2};
      pal[3] <= {L3, L3, L3};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

endmodule

// File: tb/tb_gb_vga_scaler.sv
// Randomized scoreboard bench for gb_vga_scaler on a shrunken
// raster so that several whole frames fit in a short run.
module tb_gb_vga_scaler;

  localparam int H_PIXELS = 40;
  localparam int H_FP     = 4;
  localparam int H_PULSE  = 6;
  localparam int H_BP     = 6;
  localparam int H_POL    = 0;
  localparam int V_PIXELS = 30;
  localparam int V_FP     = 2;
  localparam int V_PULSE  = 2;
  localparam int V_BP     = 3;
  localparam int V_POL    = 1;
  localparam int SRC_W    = 8;
  localparam int SRC_H    = 6;
  localparam int SCALE    = 3;
  localparam int X_OFF    = 7;
  localparam int Y_OFF    = 5;
  localparam int ADDR_W   = 6;
  localparam int COLOR_W  = 2;

  localparam int HF = H_PIXELS + H_FP + H_PULSE + H_BP;
  localparam int VF = V_PIXELS + V_FP + V_PULSE + V_BP;
  localparam int NCYC   = 3 * HF * VF + 500;
  localparam int RST_AT = 2600;

  logic       clk = 1'b0;
  logic       reset;
  logic       pal_we;
  logic [1:0] pal_idx;
  logic [5:0] pal_rgb;
  logic [5:0] border_rgb;

  always #5 clk = ~clk;

  gb_vga_scaler_if #(
    .ADDR_W (ADDR_W),
    .COLOR_W(COLOR_W)
  ) bus ();

  // framebuffer model: mem[a] = a % 4
  assign bus.fb_data = bus.fb_addr[1:0];

  gb_vga_scaler #(
    .H_PIXELS(H_PIXELS), .H_FP(H_FP),
    .H_PULSE(H_PULSE), .H_BP(H_BP), .H_POL(H_POL),
    .V_PIXELS(V_PIXELS), .V_FP(V_FP),
    .V_PULSE(V_PULSE), .V_BP(V_BP), .V_POL(V_POL),
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE),
    .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .CLK_25MHz (clk),
    .reset     (reset),
    .vga       (bus),
    .pal_we    (pal_we),
    .pal_idx   (pal_idx),
    .pal_rgb   (pal_rgb),
    .border_rgb(border_rgb)
  );

  typedef struct packed {
    logic [5:0]        rgb;
    logic              hs;
    logic              vs;
    logic              fs;
    logic [ADDR_W-1:0] addr;
    logic              any;
  } exp_t;

  exp_t       q[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [5:0] pal_m [4];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, req);
    end
  endtask

  function automatic bit in_win(int h, int v);
    return h >= X_OFF && h < X_OFF + SRC_W * SCALE &&
           v >= Y_OFF && v < Y_OFF + SRC_H * SCALE;
  endfunction

  function automatic int src_addr(int h, int v);
    return ((v - Y_OFF) / SCALE) * SRC_W + (h - X_OFF) / SCALE;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.rgb  = '0;
    e.hs   = ~1'(H_POL);
    e.vs   = ~1'(V_POL);
    e.fs   = 1'b0;
    e.addr = '0;
    e.any  = 1'b0;
    return e;
  endfunction

  // output after the k-th edge following release shows pixel k-2
  function automatic exp_t pix_exp(int n, logic [5:0] bd);
    exp_t e;
    int   h;
    int   v;
    int   hs0;
    int   vs0;
    e   = idle_exp();
    h   = n % HF;
    v   = (n / HF) % VF;
    hs0 = H_PIXELS + H_FP;
    vs0 = V_PIXELS + V_FP;
    if (h >= hs0 && h < hs0 + H_PULSE) e.hs = 1'(H_POL);
    if (v >= vs0 && v < vs0 + V_PULSE) e.vs = 1'(V_POL);
    e.fs = (h == 0) && (v == 0);
    if (h < H_PIXELS && v < V_PIXELS) begin
      if (in_win(h, v)) e.rgb = pal_m[src_addr(h, v) % 4];
      else              e.rgb = bd;
    end
    return e;
  endfunction

  task automatic pal_defaults();
    pal_m[0] = 6'b111111;
    pal_m[1] = 6'b101010;
    pal_m[2] = 6'b010101;
    pal_m[3] = 6'b000000;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}),
            32'(e.rgb));
        chk("hs", 32'(bus.vga_hs), 32'(e.hs));
        chk("vs", 32'(bus.vga_vs), 32'(e.vs));
        chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
        if (e.any)
          chk("addr_range",
              32'(int'(bus.fb_addr) < SRC_W * SRC_H), 32'd1);
        else
          chk("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   k;
    int   n;
    int   hh;
    int   vv;
    reset      = 1'b1;
    pal_we     = 1'b0;
    pal_idx    = '0;
    pal_rgb    = '0;
    border_rgb = '0;
    k          = 0;
    pal_defaults();
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      reset = (i < 3) || (i >= RST_AT && i < RST_AT + 3) ||
              ($urandom_range(0, 2999) == 0);
      border_rgb = 6'($urandom);
      pal_we     = ($urandom_range(0, 7) == 0);
      pal_idx    = 2'($urandom);
      pal_rgb    = 6'($urandom);
      if (reset) begin
        k = 0;
        e = idle_exp();
      end else begin
        k++;
        e = (k >= 2) ? pix_exp(k - 2, border_rgb) : idle_exp();
        n  = k - 1;
        hh = n % HF;
        vv = (n / HF) % VF;
        if (in_win(hh, vv)) begin
          e.addr = ADDR_W'(src_addr(hh, vv));
          e.any  = 1'b0;
        end else begin
          e.addr = '0;
          e.any  = 1'b1;
        end
      end
      q.push_back(e);
      if (reset)       pal_defaults();
      else if (pal_we) pal_m[pal_idx] = pal_rgb;
    end
    @(negedge clk);
    pal_we = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gb_vga_scaler.md
# gb_vga_scaler

Parametrised VGA output stage for the Game Boy capture path. It runs in the 25 MHz pixel domain. It generates VGA timing from parameters and drives read addresses into the dual-port framebuffer, which is written in the GB pixel-clock domain. It scales the SRC_W×SRC_H image by an integer factor at a configurable offset, maps 2-bit GB shades through a writable 4-entry palette, and paints a border colour around the image.

## Interface
Parameters:
- H_PIXELS, 640, visible columns
- H_FP, 16, H front porch
- H_PULSE, 96, H sync width
- H_BP, 48, H back porch
- H_POL, 0, H sync active level
- V_PIXELS, 480, visible lines
- V_FP, 10, V front porch
- V_PULSE, 2, V sync width
- V_BP, 33, V back porch
- V_POL, 1, V sync active level
- SRC_W, 160, source width
- SRC_H, 144, source height
- SCALE, 3, integer scale factor, ≥1
- X_OFF, 80, first image column
- Y_OFF, 24, first image line
- ADDR_W, 15, framebuffer address width
- COLOR_W, 2, bits per VGA channel

Ports:
- CLK_25MHz  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- fb_addr  out  ADDR_W  framebuffer read address
- fb_data  in  2  shade; valid one cycle after fb_addr
- pal_we  in  1  palette write strobe
- pal_idx  in  2  palette entry index
- pal_rgb  in  3*COLOR_W  write data {r,g,b}
- border_rgb  in  3*COLOR_W  border colour {r,g,b}
- vga_r, vga_g, vga_b  out  COLOR_W each  colour
- vga_hs  out  1  H sync
- vga_vs  out  1  V sync
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- Horizontal counter h runs 0..H_FRAME-1, where H_FRAME = sum of the four H parameters. At wrap, the vertical counter v runs 0..V_FRAME-1.
- Line order is visible, front porch, sync, back porch.
- hs is active for H_PULSE cycles, h ∈ [H_PIXELS+H_FP, H_PIXELS+H_FP+H_PULSE-1].
- vs is active for V_PULSE whole lines, v ∈ [V_PIXELS+V_FP, V_PIXELS+V_FP+V_PULSE-1].
- Image window is x ∈ [X_OFF, X_OFF+SRC_W*SCALE-1] and y ∈ [Y_OFF, Y_OFF+SRC_H*SCALE-1].
- Address generation is incremental, with no multiplier:
  - x_sub counts 0..SCALE-1; src_x increments when x_sub wraps.
  - y_sub and line_base behave the same way; line_base += SRC_W every SCALE image lines.
  - fb_addr = line_base + src_x.
- Elaboration must fail if X_OFF+SRC_W*SCALE > H_PIXELS, if Y_OFF+SRC_H*SCALE > V_PIXELS, or if SRC_W*SRC_H > 2^ADDR_W.
- Colour selection:
  - Blanking: all channels 0.
  - Visible but outside the window: border_rgb.
  - Inside the window: palette[fb_data].
- Palette reset values, per channel: idx0 = all ones, idx1 = 2/3 full scale (2'b10 at COLOR_W=2), idx2 = 1/3 (2'b01), idx3 = 0. Each channel gets the same value.
- Palette write: when pal_we=1, palette[pal_idx] ← pal_rgb at the clock edge. A pixel looked up in that same cycle uses the old value.

## Timing
- Three-stage pipeline:
  - S0: counters.
  - S1: fb_addr registered; window, blank and sync flags delayed.
  - S2: fb_data and palette lookup registered to vga_*; syncs registered alongside.
- vga_*, vga_hs, vga_vs and frame_start for counter position (h,v) appear 2 cycles after S0 holds (h,v). Syncs and colour are always mutually aligned.
- fb_addr is presented exactly 1 cycle before its pixel's fb_data is consumed.
- Reset values (held while reset=1):
  - h = v = 0; sub-counters, src_x and line_base = 0.
  - fb_addr = 0; vga_r/g/b = 0.
  - vga_hs = ~H_POL; vga_vs = ~V_POL; frame_start = 0.
  - Palette returns to its defaults.
- Reset mid-frame: all of the above take effect on the next edge; in-flight pipeline data is discarded.
- After release, counters advance from (0,0) on the first edge with reset=0. frame_start is high for the cycle after the second such edge.
- fb_addr range 0..SRC_W*SRC_H-1. It returns to 0 for the next frame with no overrun.
- fb_addr outside the window is don't-care, but must stay in range.

## Test plan
- Horizontal timing: release reset → vga_hs falling edges exactly 800 cycles apart; hs low for 96 cycles; first hs assertion at output cycle h=656.
- Vertical timing: run a full frame → vga_vs high for exactly 1600 cycles; vs rises every 420000 cycles; frame_start has the same 420000-cycle period.
- Address mapping: fb model returns mem[a] = a%4; sample fb_addr at S1 for each pixel:
  - (80,24)→0, (82,26)→0, (83,24)→1, (80,27)→160, (559,455)→23039.
  - Output colours match the default palette: (83,24) gives 2'b10 on all channels.
- Border and blank: border_rgb = 6'b110001 → pixels (0,0), (79,24) and (560,300) output r=3, g=0, b=1; any h ≥ 640 or v ≥ 480 outputs 0.
- Palette write: mid-image, pal_we with idx 2 and rgb 6'b110000 → shade-2 pixels looked up in that cycle keep 2'b01 grey; from the next lookup they output r=3, g=0, b=0.
- Reset mid-line: assert reset at h=300, v=100 for 3 cycles → next edge gives vga_*=0, hs=1, vs=0 and default palette. frame_start pulses once, 2 edges after release, together with pixel (0,0) at border colour.
